// File: rtl/lights_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | lights_sequencer : colour code / sel controller, auto dwell + manual step |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lights_sequencer #(
   parameter int DWELL       = 8,
   parameter int MAN_TIMEOUT = 32,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       auto_req,
   input  logic       button,
   output logic [2:0] colour,
   output logic       sel,
   output logic       step,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_AUTO   = 2'b01,
      ST_MANUAL = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(MAN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [2:0]       COLOUR_FIRST = 3'd1;
   localparam logic [2:0]       COLOUR_LAST  = 3'd6;

   state_t           state;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] idle_cnt;
   logic             btn_q;
   logic             btn_edge;
   logic [2:0]       colour_next;

   assign btn_edge    = button & ~btn_q;
   assign colour_next = (colour == COLOUR_LAST) ? COLOUR_FIRST : colour + 3'd1;
   assign mode        = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         colour    <= COLOUR_FIRST;
         sel       <= 1'b0;
         step      <= 1'b0;
         dwell_cnt <= '0;
         idle_cnt  <= '0;
         btn_q     <= button;
      end else begin
         btn_q <= button;
         step  <= 1'b0;
         if (!enable) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            dwell_cnt <= '0;
            idle_cnt  <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state     <= auto_req ? ST_AUTO : ST_MANUAL;
                  sel       <= 1'b1;
                  dwell_cnt <= '0;
                  idle_cnt  <= '0;
               end
               ST_AUTO: begin
                  // A button edge coinciding with dwell expiry still gives a single advance
                  if (btn_edge) begin
                     state     <= ST_MANUAL;
                     colour    <= colour_next;
                     step      <= 1'b1;
                     dwell_cnt <= '0;
                     idle_cnt  <= '0;
                  end else if (!auto_req) begin
                     state     <= ST_MANUAL;
                     dwell_cnt <= '0;
                     idle_cnt  <= '0;
                  end else if (dwell_cnt == DWELL_LAST) begin
                     colour    <= colour_next;
                     step      <= 1'b1;
                     dwell_cnt <= '0;
                  end else begin
                     dwell_cnt <= dwell_cnt + CNT_ONE;
                  end
               end
               ST_MANUAL: begin
                  if (btn_edge) begin
                     colour   <= colour_next;
                     step     <= 1'b1;
                     idle_cnt <= '0;
                  end else if ((idle_cnt == IDLE_LAST) && auto_req) begin
                     state     <= ST_AUTO;
                     dwell_cnt <= '0;
                     idle_cnt  <= '0;
                  end else if (idle_cnt != IDLE_LAST) begin
                     idle_cnt <= idle_cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  sel   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
